csr_unit: RTL
=============

// Module: csr_unit
// PURPOSE
//  Parametrised machine-mode CSR unit: next generation of the core's CSR file. Adds CSRRW/RS/RC
//  read-modify-write, hardware trap entry and MRET stacking of mstatus, 64-bit mcycle/minstret
//  counters, live interrupt-pending sampling and illegal-access flagging. Sits between decode
//  (read port) and memory stage (write/trap port). Feeds trap/redirect logic.
// PARAMETERS
//  XLEN         32            data width; only 32 supported, checked by elaboration assert
//  MISA_RESET   32'h40100100  misa value (read-only)
//  MTVEC_RESET  32'h0         mtvec reset value
//  MHARTID      0             mhartid value (read-only, 0xF14)
//  HAS_COUNTERS 1             1: mcycle/minstret(+h) implemented; 0: they read 0, writes ignored
// PORTS
//  clk                input  1     clock, all state on posedge
//  reset              input  1     synchronous, active-high
//  CSR_RADR_SD        input  12    read address (decode)
//  CSR_RDATA_SC       output XLEN  read data, combinational from current state
//  CSR_ILLEGAL_SC     output 1     1 = CSR_RADR_SD unimplemented (comb)
//  CSR_ENABLE_SM      input  1     write request (mem stage)
//  CSR_WADR_SM        input  12    write address
//  CSR_OP_SM          input  2     01 RW, 10 RS (set), 11 RC (clear); 00 = no write
//  CSR_WDATA_SM       input  XLEN  operand (rs1 or zimm, zero-extended)
//  CSR_WILLEGAL_SC    output 1     1 = write to unimplemented or read-only address (comb)
//  EXCEPTION_SM       input  1     trap entry this cycle
//  MCAUSE_WDATA_SM    input  XLEN  trap cause
//  MEPC_WDATA_SM      input  XLEN  trap pc
//  MTVAL_WDATA_SM     input  XLEN  trap value
//  MRET_SM            input  1     mret retiring this cycle
//  RETIRE_SM          input  1     one instruction retired (minstret increment)
//  IRQ_EXT/TIMER/SOFT input  1 ea  level interrupt sources -> mip.MEIP(11)/MTIP(7)/MSIP(3)
//  IRQ_PENDING_SC     output 1     mstatus.MIE & |(mip & mie)
//  MEPC_SC/MTVEC_VALUE_RC/MSTATUS_RC/MCAUSE_SC output XLEN  direct register views
// BEHAVIOUR
//  Reset (sync): all regs 0 except misa=MISA_RESET, mtvec=MTVEC_RESET; counters 0; outputs follow.
//  Implemented: F11-F14, 300, 301, 304, 305, 310, 340-344, and if HAS_COUNTERS B00/B02/B80/B82.
//  Write data: RW new=op; RS new=old|op; RC new=old&~op; old = current register value.
//  Writes commit at posedge when CSR_ENABLE_SM & OP!=00 & !CSR_WILLEGAL_SC. Read sees new value next cycle.
//  WARL masks: mstatus writable bits MIE(3), MPIE(7), MPP(12:11) only; MPP reads 2'b11 always;
//   mtvec[1:0] forced 00 (direct); mepc[1:0] forced 0; mie writable 3,7,11; mip bits 3/7/11 read-only
//   (writes ignored), other mip bits 0. mstatush reads 0.
//  Priority same cycle: reset > EXCEPTION_SM > MRET_SM > CSR write. Lower ones dropped entirely.
//  Trap entry: mepc<=MEPC_WDATA&~3, mcause, mtval loaded; MPIE<=MIE; MIE<=0.
//  MRET: MIE<=MPIE; MPIE<=1. mepc unchanged.
//  mip[3/7/11] registered from IRQ_* each cycle (1-cycle latency to IRQ_PENDING_SC).
//  mcycle: +1 every cycle after reset, 64-bit, wraps FFFF_FFFF_FFFF_FFFF->0 with carry low->high.
//  minstret: +1 when RETIRE_SM (also on trap cycle if asserted).
//  Counter write to low/high half replaces that half; the increment is suppressed for the whole
//   64-bit counter that cycle (written value holds exactly one cycle, then counting resumes).
//  Counter write on trap cycle is dropped (priority rule); counting continues.
// STRUCTURE
//  river_pkg: CSR address localparams, csr_op_e enum (NONE/RW/RS/RC), mstatus bit-index constants,
//   mip/mie bit masks, cause codes.
//  Sub-module csr_counter64 (clk, reset, inc, wr_lo, wr_hi, wdata, value[63:0]) instantiated twice.
// TESTING
//  Reset, read 301/F14/305 -> 40100100 / MHARTID / MTVEC_RESET; read 0x7C0 -> ILLEGAL_SC=1, data 0.
//  RW 300 <=FFFF_FFFF; read -> 0000_1888. RS 304 op=0x8 then RC op=0x8 -> mie 8 then 0.
//  mstatus.MIE=1, trap cause 2 epc 0x1002 -> mepc 0x1000, MIE 0, MPIE 1; MRET -> MIE 1, MPIE 1.
//  Trap and CSR write to 341 same cycle -> mepc = trap value; write lost.
//  Write mcycle lo=FFFF_FFFF, hi=0 (two writes) -> after 1 cycle reads 0000_0001_0000_0000 pattern
//   (lo 0, hi 1 one cycle after lo write holds); write to F11 -> WILLEGAL_SC=1, no state change.
//  mie=0x800, MIE=1, raise IRQ_EXT -> IRQ_PENDING_SC 1 exactly one cycle later; drop -> 0 next cycle.

Source files
------------

// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, operation
// encoding, mstatus bit positions, interrupt masks and cause codes.
package csr_unit_pkg;

  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH  = 12'h310;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MIP_MSIP = 32'h0000_0008;
  localparam logic [31:0] MIP_MTIP = 32'h0000_0080;
  localparam logic [31:0] MIP_MEIP = 32'h0000_0800;
  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT   = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M      = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_SOFT     = 32'h8000_0003;
  localparam logic [31:0] CAUSE_IRQ_TIMER    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_IRQ_EXT      = 32'h8000_000B;

  function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] old_value,
                                               logic [31:0] operand);
    case (op)
      CSR_OP_RW: return operand;
      CSR_OP_RS: return old_value | operand;
      CSR_OP_RC: return old_value & ~operand;
      default:   return old_value;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Decode read port, memory-stage write/trap port, interrupt lines and
// register views of the CSR unit, bundled for the pipeline.
interface csr_unit_if import csr_unit_pkg::*; #(parameter int XLEN = 32);
  logic [11:0]     CSR_RADR_SD;
  logic [XLEN-1:0] CSR_RDATA_SC;
  logic            CSR_ILLEGAL_SC;
  logic            CSR_ENABLE_SM;
  logic [11:0]     CSR_WADR_SM;
  csr_op_e         CSR_OP_SM;
  logic [XLEN-1:0] CSR_WDATA_SM;
  logic            CSR_WILLEGAL_SC;
  logic            EXCEPTION_SM;
  logic [XLEN-1:0] MCAUSE_WDATA_SM;
  logic [XLEN-1:0] MEPC_WDATA_SM;
  logic [XLEN-1:0] MTVAL_WDATA_SM;
  logic            MRET_SM;
  logic            RETIRE_SM;
  logic            IRQ_EXT;
  logic            IRQ_TIMER;
  logic            IRQ_SOFT;
  logic            IRQ_PENDING_SC;
  logic [XLEN-1:0] MEPC_SC;
  logic [XLEN-1:0] MTVEC_VALUE_RC;
  logic [XLEN-1:0] MSTATUS_RC;
  logic [XLEN-1:0] MCAUSE_SC;

  modport master (
    output CSR_RADR_SD, CSR_ENABLE_SM, CSR_WADR_SM, CSR_OP_SM, CSR_WDATA_SM,
           EXCEPTION_SM, MCAUSE_WDATA_SM, MEPC_WDATA_SM, MTVAL_WDATA_SM,
           MRET_SM, RETIRE_SM, IRQ_EXT, IRQ_TIMER, IRQ_SOFT,
    input  CSR_RDATA_SC, CSR_ILLEGAL_SC, CSR_WILLEGAL_SC, IRQ_PENDING_SC,
           MEPC_SC, MTVEC_VALUE_RC, MSTATUS_RC, MCAUSE_SC
  );

  modport slave (
    input  CSR_RADR_SD, CSR_ENABLE_SM, CSR_WADR_SM, CSR_OP_SM, CSR_WDATA_SM,
           EXCEPTION_SM, MCAUSE_WDATA_SM, MEPC_WDATA_SM, MTVAL_WDATA_SM,
           MRET_SM, RETIRE_SM, IRQ_EXT, IRQ_TIMER, IRQ_SOFT,
    output CSR_RDATA_SC, CSR_ILLEGAL_SC, CSR_WILLEGAL_SC, IRQ_PENDING_SC,
           MEPC_SC, MTVEC_VALUE_RC, MSTATUS_RC, MCAUSE_SC
  );
endinterface

// File: rtl/csr_unit_counter64.sv
// 64-bit free-running counter with independently writable halves; a write
// to either half holds the whole counter for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) value[31:0]  <= wdata;
      if (wr_hi) value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: read/modify/write access, trap entry and MRET
// stacking, cycle/instret counters and interrupt-pending generation.
module csr_unit import csr_unit_pkg::*; #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] MISA_RESET   = 32'h4010_0100,
  parameter logic [31:0] MTVEC_RESET  = 32'h0,
  parameter logic [31:0] MHARTID      = 32'h0,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input logic       clk,
  input logic       reset,
  csr_unit_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("csr_unit supports XLEN=32 only");
  end

  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mie_q, mip_q;
  logic [XLEN-1:0] mstatus_view;
  logic [63:0]     mcycle, minstret;

  // Port 0 serves decode reads, port 1 supplies the old value for writes.
  logic [11:0]     look_addr [2];
  logic [XLEN-1:0] look_data [2];
  logic            look_hit  [2];
  assign look_addr[0] = bus.CSR_RADR_SD;
  assign look_addr[1] = bus.CSR_WADR_SM;

  always_comb begin
    mstatus_view = '0;
    mstatus_view[MSTATUS_MIE] = mstatus_mie;
    mstatus_view[MSTATUS_MPIE] = mstatus_mpie;
    mstatus_view[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      look_data[p] = '0;
      look_hit[p] = 1'b1;
      case (look_addr[p])
        CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MSTATUSH: look_data[p] = '0;
        CSR_MHARTID:  look_data[p] = MHARTID;
        CSR_MSTATUS:  look_data[p] = mstatus_view;
        CSR_MISA:     look_data[p] = MISA_RESET;
        CSR_MIE:      look_data[p] = mie_q;
        CSR_MTVEC:    look_data[p] = mtvec_q;
        CSR_MSCRATCH: look_data[p] = mscratch_q;
        CSR_MEPC:     look_data[p] = mepc_q;
        CSR_MCAUSE:   look_data[p] = mcause_q;
        CSR_MTVAL:    look_data[p] = mtval_q;
        CSR_MIP:      look_data[p] = mip_q;
        CSR_MCYCLE:    begin look_hit[p] = HAS_COUNTERS; look_data[p] = mcycle[31:0];    end
        CSR_MCYCLEH:   begin look_hit[p] = HAS_COUNTERS; look_data[p] = mcycle[63:32];   end
        CSR_MINSTRET:  begin look_hit[p] = HAS_COUNTERS; look_data[p] = minstret[31:0];  end
        CSR_MINSTRETH: begin look_hit[p] = HAS_COUNTERS; look_data[p] = minstret[63:32]; end
        default:      look_hit[p] = 1'b0;
      endcase
    end
  end

  logic            wr_req, read_only, do_write;
  logic [XLEN-1:0] wnew;

  assign read_only = (bus.CSR_WADR_SM[11:8] == 4'hF) || (bus.CSR_WADR_SM == CSR_MISA);
  assign wr_req    = bus.CSR_ENABLE_SM && (bus.CSR_OP_SM != CSR_OP_NONE);
  assign bus.CSR_WILLEGAL_SC = wr_req && (!look_hit[1] || read_only);
  // Trap and MRET own the cycle; a coincident CSR write is dropped.
  assign do_write  = wr_req && !bus.CSR_WILLEGAL_SC && !bus.EXCEPTION_SM && !bus.MRET_SM;
  assign wnew      = csr_apply_op(bus.CSR_OP_SM, look_data[1], bus.CSR_WDATA_SM);

  assign bus.CSR_RDATA_SC   = look_data[0];
  assign bus.CSR_ILLEGAL_SC = !look_hit[0];
  assign bus.IRQ_PENDING_SC = mstatus_mie && |(mip_q & mie_q);
  assign bus.MEPC_SC        = mepc_q;
  assign bus.MTVEC_VALUE_RC = mtvec_q;
  assign bus.MSTATUS_RC     = mstatus_view;
  assign bus.MCAUSE_SC      = mcause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mtvec_q      <= MTVEC_RESET & ~32'h3;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mie_q        <= '0;
      mip_q        <= '0;
    end else begin
      mip_q <= (bus.IRQ_EXT ? MIP_MEIP : '0) | (bus.IRQ_TIMER ? MIP_MTIP : '0)
             | (bus.IRQ_SOFT ? MIP_MSIP : '0);
      if (bus.EXCEPTION_SM) begin
        mepc_q       <= bus.MEPC_WDATA_SM & ~32'h3;
        mcause_q     <= bus.MCAUSE_WDATA_SM;
        mtval_q      <= bus.MTVAL_WDATA_SM;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (bus.MRET_SM) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (do_write) begin
        case (bus.CSR_WADR_SM)
          CSR_MSTATUS: begin
            mstatus_mie  <= wnew[MSTATUS_MIE];
            mstatus_mpie <= wnew[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= wnew & IRQ_MASK;
          CSR_MTVEC:    mtvec_q    <= wnew & ~32'h3;
          CSR_MSCRATCH: mscratch_q <= wnew;
          CSR_MEPC:     mepc_q     <= wnew & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= wnew;
          CSR_MTVAL:    mtval_q    <= wnew;
          default: ;
        endcase
      end
    end
  end

  if (HAS_COUNTERS) begin : g_counters
    csr_counter64 u_mcycle (
      .clk(clk), .reset(reset), .inc(1'b1),
      .wr_lo(do_write && bus.CSR_WADR_SM == CSR_MCYCLE),
      .wr_hi(do_write && bus.CSR_WADR_SM == CSR_MCYCLEH),
      .wdata(wnew), .value(mcycle)
    );
    csr_counter64 u_minstret (
      .clk(clk), .reset(reset), .inc(bus.RETIRE_SM),
      .wr_lo(do_write && bus.CSR_WADR_SM == CSR_MINSTRET),
      .wr_hi(do_write && bus.CSR_WADR_SM == CSR_MINSTRETH),
      .wdata(wnew), .value(minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

endmodule
